// File: rtl/bf_core_nested.sv
// bf_core_nested: parametrised Brainfuck core with nested loop skipping, stack error checks
// and an explicit 0x00 program end that writes back the cached cell before halting.
module bf_core_nested #(
    parameter int CELL_WIDTH      = 8,
    parameter int DATA_ADDR_WIDTH = 8,
    parameter int ROM_ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH     = 8,
    parameter bit CLEAR_RAM       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rom_i,
    output logic [ROM_ADDR_WIDTH-1:0]  rom_addr_o,
    input  logic [CELL_WIDTH-1:0]      data_i,
    output logic [CELL_WIDTH-1:0]      data_o,
    output logic [DATA_ADDR_WIDTH-1:0] data_addr_o,
    output logic                       rd,
    output logic                       wr,
    output logic                       mreq,
    output logic                       ioreq,
    input  logic                       ready,
    output logic                       halted,
    output logic                       error,
    output logic [1:0]                 error_code
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    typedef enum logic [3:0] {
        S_START, S_CLEAR, S_FETCH, S_RUN, S_READ, S_SKIP, S_JUMP, S_HALT_WB, S_HALT, S_ERROR
    } state_t;
    state_t                     state;
    logic [ROM_ADDR_WIDTH-1:0]  pc;
    logic [ROM_ADDR_WIDTH-1:0]  depth;
    logic [DATA_ADDR_WIDTH-1:0] pointer;
    logic [SPW-1:0]             sp;
    logic [CELL_WIDTH-1:0]      data_reg;
    logic [7:0]                 ir;
    logic [ROM_ADDR_WIDTH-1:0]  stack [2**SPW];
    logic                       run, is_mv, push;
    logic [SPW-1:0]             sp_m1;
    assign run   = state == S_RUN;
    assign is_mv = ir == 8'h3C || ir == 8'h3E;
    assign sp_m1 = sp - 1'b1;
    assign push  = run && ir == 8'h5B && data_reg != '0 && sp != SP_FULL;
    assign wr    = state == S_CLEAR || state == S_HALT_WB || (run && (is_mv || ir == 8'h2E));
    assign rd    = state == S_READ || (run && ir == 8'h2C);
    assign mreq  = state == S_CLEAR || state == S_HALT_WB || state == S_READ || (run && is_mv);
    assign ioreq = run && (ir == 8'h2C || ir == 8'h2E);
    assign rom_addr_o  = pc;
    assign data_addr_o = pointer;
    assign data_o      = state == S_CLEAR ? '0 : data_reg;
    assign halted      = state == S_HALT;
    assign error       = state == S_ERROR;
    // Stack entries carry no reset; only slots below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_START;
            pc         <= '0;
            depth      <= '0;
            pointer    <= '0;
            sp         <= '0;
            data_reg   <= '0;
            ir         <= '0;
            error_code <= '0;
        end else begin
            case (state)
                S_START: state <= CLEAR_RAM ? S_CLEAR : S_FETCH;
                S_CLEAR: if (ready) begin
                    pointer <= pointer + 1'b1;
                    if (&pointer) state <= S_FETCH;
                end
                S_FETCH, S_JUMP: begin
                    ir    <= rom_i;
                    pc    <= pc + 1'b1;
                    state <= S_RUN;
                end
                S_READ: if (ready) begin
                    data_reg <= data_i;
                    state    <= S_RUN;
                end
                S_HALT_WB: if (ready) state <= S_HALT;
                S_SKIP: begin
                    if (ir == 8'h5D && depth == '0) begin
                        ir    <= rom_i;
                        pc    <= pc + 1'b1;
                        state <= S_RUN;
                    end else if (ir == 8'h00 || pc == '0) begin
                        state      <= S_ERROR;
                        error_code <= 2'b11;
                    end else begin
                        ir    <= rom_i;
                        pc    <= pc + 1'b1;
                        depth <= ir == 8'h5B ? depth + 1'b1 : ir == 8'h5D ? depth - 1'b1 : depth;
                    end
                end
                S_RUN: begin
                    case (ir)
                        8'h2B, 8'h2D: begin
                            data_reg <= ir == 8'h2B ? data_reg + 1'b1 : data_reg - 1'b1;
                            ir       <= rom_i;
                            pc       <= pc + 1'b1;
                        end
                        8'h3C, 8'h3E: if (ready) begin
                            pointer <= ir == 8'h3E ? pointer + 1'b1 : pointer - 1'b1;
                            ir      <= rom_i;
                            pc      <= pc + 1'b1;
                            state   <= S_READ;
                        end
                        8'h2C, 8'h2E: if (ready) begin
                            if (ir == 8'h2C) data_reg <= data_i;
                            ir <= rom_i;
                            pc <= pc + 1'b1;
                        end
                        8'h5B: begin
                            if (data_reg != '0 && sp == SP_FULL) begin
                                state      <= S_ERROR;
                                error_code <= 2'b01;
                            end else begin
                                if (data_reg != '0) sp <= sp + 1'b1;
                                else begin
                                    depth <= '0;
                                    state <= S_SKIP;
                                end
                                ir <= rom_i;
                                pc <= pc + 1'b1;
                            end
                        end
                        8'h5D: begin
                            if (sp == '0) begin
                                state      <= S_ERROR;
                                error_code <= 2'b10;
                            end else if (data_reg != '0) begin
                                pc    <= stack[sp_m1];
                                state <= S_JUMP;
                            end else begin
                                sp <= sp_m1;
                                ir <= rom_i;
                                pc <= pc + 1'b1;
                            end
                        end
                        8'h00: state <= S_HALT_WB;
                        default: begin
                            ir <= rom_i;
                            pc <= pc + 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bf_core_nested.sv
// tb_bf_core_nested: scoreboard bench; expected RAM/IO writes are queued by the stimulus
// and popped by negedge monitors whenever the DUT completes a write.
module tb_bf_core_nested;
    logic clk = 1'b0, rst = 1'b1, rst_b = 1'b1, ready = 1'b0;
    int checks = 0, errors = 0, ready_mode = 1;
    always #5 clk = ~clk;
    logic [7:0]  rom [4096];
    logic [7:0]  ram [16];
    logic [7:0]  rom_b [4096];
    logic [7:0]  io_q [$];
    logic [11:0] mem_q [$];
    logic [15:0] io_qb [$];
    logic [19:0] mem_qb [$];
    logic [11:0] rom_addr_a, rom_addr_b;
    logic [7:0]  rom_i_a, data_i_a, data_o_a;
    logic [3:0]  data_addr_a, data_addr_b;
    logic        rd_a, wr_a, mreq_a, ioreq_a, halted_a, error_a;
    logic [1:0]  error_code_a, error_code_b;
    logic [7:0]  rom_i_b;
    logic [15:0] data_o_b;
    logic        rd_b, wr_b, mreq_b, ioreq_b, halted_b, error_b;
    assign rom_i_a  = rom[rom_addr_a];
    assign data_i_a = mreq_a ? ram[data_addr_a] : 8'h41;
    assign rom_i_b  = rom_b[rom_addr_b];
    bf_core_nested #(.CELL_WIDTH(8), .DATA_ADDR_WIDTH(4), .ROM_ADDR_WIDTH(12), .STACK_DEPTH(2), .CLEAR_RAM(1'b1)) u_a (
        .clk(clk), .rst(rst), .rom_i(rom_i_a), .rom_addr_o(rom_addr_a), .data_i(data_i_a),
        .data_o(data_o_a), .data_addr_o(data_addr_a), .rd(rd_a), .wr(wr_a), .mreq(mreq_a),
        .ioreq(ioreq_a), .ready(ready), .halted(halted_a), .error(error_a), .error_code(error_code_a));
    bf_core_nested #(.CELL_WIDTH(16), .DATA_ADDR_WIDTH(4), .ROM_ADDR_WIDTH(12), .STACK_DEPTH(2), .CLEAR_RAM(1'b0)) u_b (
        .clk(clk), .rst(rst_b), .rom_i(rom_i_b), .rom_addr_o(rom_addr_b), .data_i(16'h0),
        .data_o(data_o_b), .data_addr_o(data_addr_b), .rd(rd_b), .wr(wr_b), .mreq(mreq_b),
        .ioreq(ioreq_b), .ready(ready), .halted(halted_b), .error(error_b), .error_code(error_code_b));
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // ready changes just after posedge so it is stable from the monitor's negedge to the next edge
    initial forever begin
        @(posedge clk);
        #1 ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    always @(negedge clk) begin
        if (!rst && ready && wr_a && mreq_a) begin
            ram[data_addr_a] = data_o_a;
            if (mem_q.size() == 0) chk("mem_extra", {data_addr_a, data_o_a}, 12'hFFF);
            else chk("mem_write", {data_addr_a, data_o_a}, mem_q.pop_front());
        end
        if (!rst && ready && wr_a && ioreq_a) begin
            if (io_q.size() == 0) chk("io_extra", data_o_a, 32'hFFFF_FFFF);
            else chk("io_write", data_o_a, io_q.pop_front());
        end
        if (!rst_b && ready && wr_b && mreq_b) begin
            if (mem_qb.size() == 0) chk("mem_b_extra", {data_addr_b, data_o_b}, 20'hFFFFF);
            else chk("mem_b_write", {data_addr_b, data_o_b}, mem_qb.pop_front());
        end
        if (!rst_b && ready && wr_b && ioreq_b) begin
            if (io_qb.size() == 0) chk("io_b_extra", data_o_b, 32'hFFFF_FFFF);
            else chk("io_b_write", data_o_b, io_qb.pop_front());
        end
    end
    task automatic prep(string p);
        @(negedge clk);
        rst = 1'b1;
        io_q.delete();
        mem_q.delete();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        for (int i = 0; i < p.len(); i++) rom[i] = p[i];
        for (int i = 0; i < 16; i++) ram[i] = 8'hA5;
        for (int i = 0; i < 16; i++) mem_q.push_back({4'(i), 8'h00});
    endtask
    task automatic go(string name, logic exp_halt, logic [1:0] exp_code);
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!(halted_a || error_a) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, n < 5000, 1);
        repeat (3) @(negedge clk);
        chk({name, "_halted"}, halted_a, exp_halt);
        chk({name, "_error"}, error_a, !exp_halt);
        chk({name, "_code"}, error_code_a, exp_code);
        chk({name, "_io_left"}, io_q.size(), 0);
        chk({name, "_mem_left"}, mem_q.size(), 0);
    endtask
    initial begin
        int nz, n;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {rd_a, wr_a, mreq_a, ioreq_a}, 4'b0000);
        chk("rst_status", {halted_a, error_a, error_code_a}, 4'b0000);
        chk("rst_addrs", {rom_addr_a, data_addr_a}, 16'h0000);
        chk("rst_data", data_o_a, 8'h00);
        // Clear sweep with ready held high, then a lone '.' of the cleared cell.
        ready_mode = 1;
        prep(".");
        io_q.push_back(8'h00);
        mem_q.push_back({4'd0, 8'h00});
        go("clear", 1'b1, 2'b00);
        nz = 0;
        for (int i = 0; i < 16; i++) nz += (ram[i] != 8'h00);
        chk("clear_ram_zero", nz, 0);
        ready_mode = 0;
        prep("+++.>,.");
        io_q.push_back(8'h03);
        io_q.push_back(8'h41);
        mem_q.push_back({4'd0, 8'h03});
        mem_q.push_back({4'd1, 8'h41});
        go("io", 1'b1, 2'b00);
        chk("io_ram0", ram[0], 8'h03);
        chk("io_ram1", ram[1], 8'h41);
        prep("++[>+++<-]>.");
        io_q.push_back(8'h06);
        mem_q.push_back({4'd0, 8'h02});
        mem_q.push_back({4'd1, 8'h03});
        mem_q.push_back({4'd0, 8'h01});
        mem_q.push_back({4'd1, 8'h06});
        mem_q.push_back({4'd0, 8'h00});
        mem_q.push_back({4'd1, 8'h06});
        go("loop", 1'b1, 2'b00);
        chk("loop_sp", u_a.sp, 0);
        prep("[[+]+].");
        io_q.push_back(8'h00);
        mem_q.push_back({4'd0, 8'h00});
        go("nest_skip", 1'b1, 2'b00);
        prep("+[[[");
        go("overflow", 1'b0, 2'b01);
        prep("]");
        go("underflow", 1'b0, 2'b10);
        prep("[++");
        go("unmatched", 1'b0, 2'b11);
        // Reset arriving while a RAM read is outstanding.
        ready_mode = 1;
        prep(">");
        mem_q.push_back({4'd0, 8'h00});
        ready_mode = 2;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!(rd_a && mreq_a) && n < 200) begin
            @(negedge clk);
            if (wr_a && mreq_a) ready_mode = (data_addr_a == 4'd15 || mem_q.size() <= 1) ? 1 : 1;
            n++;
        end
        chk("rdrst_reached", n < 200, 1);
        rst = 1'b1;
        #1 chk("rdrst_async", {rd_a, wr_a, mreq_a, ioreq_a}, 4'b0000);
        @(posedge clk);
        #1 chk("rdrst_edge", {rd_a, wr_a, mreq_a, ioreq_a}, 4'b0000);
        chk("rdrst_mem_left", mem_q.size(), 0);
        // 16-bit cell, no clear: decrement wraps to all-ones.
        ready_mode = 0;
        for (int i = 0; i < 4096; i++) rom_b[i] = 8'h00;
        rom_b[0] = 8'h2D;
        rom_b[1] = 8'h2E;
        io_qb.push_back(16'hFFFF);
        mem_qb.push_back({4'd0, 16'hFFFF});
        @(negedge clk);
        rst_b = 1'b0;
        n = 0;
        while (!(halted_b || error_b) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("w16_done", n < 500, 1);
        chk("w16_halted", {halted_b, error_b, error_code_b}, 4'b1000);
        chk("w16_io_left", io_qb.size(), 0);
        chk("w16_mem_left", mem_qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
